// File: rtl/cbd_sampler_multi.sv
// Multi-lane centered-binomial sampler (eta 2/3) with per-lane 64-bit bit-repacking buffers.
// Define CBD_MODQ_EN to emit negative coefficients as coef+3329 (unsigned, zero-extended).

module cbd_lane (
    input  logic        clk,
    input  logic        reset,
    input  logic        clr,
    input  logic        acc,
    input  logic        ld,
    input  logic        e3,
    input  logic [6:0]  cnt,
    input  logic [31:0] din,
    output logic [15:0] dout
);
    logic [63:0] bits_q;
    logic [63:0] bits_shf;
    logic [63:0] bits_d;
    logic [6:0]  shamt;
    logic [6:0]  wpos;
    logic [1:0]  a;
    logic [1:0]  b;
    logic [2:0]  coef;
    logic [15:0] coef_fmt;

    always_comb begin
        shamt    = e3 ? 7'd6 : 7'd4;
        a        = {1'b0, bits_q[0]} + {1'b0, bits_q[1]} + (e3 ? {1'b0, bits_q[2]} : 2'd0);
        b        = e3 ? ({1'b0, bits_q[3]} + {1'b0, bits_q[4]} + {1'b0, bits_q[5]})
                      : ({1'b0, bits_q[2]} + {1'b0, bits_q[3]});
        // 3-bit two's complement difference, range [-3,3]
        coef     = {1'b0, a} - {1'b0, b};
`ifdef CBD_MODQ_EN
        coef_fmt = coef[2] ? (16'd3329 - {13'd0, 3'd0 - coef}) : {13'd0, coef};
`else
        coef_fmt = {{13{coef[2]}}, coef};
`endif
        // A same-cycle load shifts first, so the new word lands at cnt-2E
        bits_shf = ld ? (bits_q >> shamt) : bits_q;
        wpos     = ld ? (cnt - shamt) : cnt;
        bits_d   = acc ? (bits_shf | ({32'd0, din} << wpos)) : bits_shf;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bits_q <= '0;
            dout   <= '0;
        end else if (clr) begin
            bits_q <= '0;
        end else begin
            bits_q <= bits_d;
            if (ld)
                dout <= coef_fmt;
        end
    end
endmodule

module cbd_sampler_multi #(
    parameter int LANES = 2,
    parameter int NCOEF = 256
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 set,
    input  logic                 eta3,
    input  logic                 readin,
    input  logic [LANES*32-1:0]  cbd_din,
    output logic                 ok_in,
    input  logic                 readout,
    output logic [LANES*16-1:0]  cbd_dout,
    output logic                 ok_out,
    output logic                 busy,
    output logic                 done
);
    localparam int CW = $clog2(NCOEF + 1);
    localparam int WW = $clog2(NCOEF * 3 / 16 + 1);
    localparam logic [WW-1:0] WORDS_E2 = WW'(NCOEF / 8);
    localparam logic [WW-1:0] WORDS_E3 = WW'(NCOEF * 3 / 16);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t          state, state_d;
    logic            e3_q;
    logic [6:0]      cnt_q, cnt_d, step;
    logic [CW-1:0]   coef_cnt;
    logic [WW-1:0]   words_in, words_max;
    logic            acc, ld, start, abort, clr;

    logic [LANES-1:0][31:0] din_l;
    logic [LANES-1:0][15:0] dout_l;

    assign din_l    = cbd_din;
    assign cbd_dout = dout_l;

    always_comb begin
        step      = e3_q ? 7'd6 : 7'd4;
        words_max = e3_q ? WORDS_E3 : WORDS_E2;
        start     = (state == S_IDLE) && set;
        abort     = ((state == S_RUN) || (state == S_DRAIN)) && !set;
        clr       = start || abort;
        ok_in     = (state == S_RUN) && (cnt_q <= 7'd32) && (words_in < words_max);
        acc       = readin && ok_in;
        ld        = (state == S_RUN) && set && (!ok_out || readout)
                    && (cnt_q >= step) && (coef_cnt < CW'(NCOEF));
        cnt_d     = cnt_q - (ld ? step : 7'd0) + (acc ? 7'd32 : 7'd0);
        busy      = (state != S_IDLE);
        done      = (state == S_DONE);
    end

    always_comb begin
        state_d = state;
        case (state)
            S_IDLE:  if (set) state_d = S_RUN;
            S_RUN:   if (!set) state_d = S_IDLE;
                     else if (coef_cnt == CW'(NCOEF)) state_d = S_DRAIN;
            // The last coefficient may already have left while still in RUN
            S_DRAIN: if (!set) state_d = S_IDLE;
                     else if (!ok_out || readout) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= S_IDLE;
            e3_q     <= 1'b0;
            cnt_q    <= '0;
            coef_cnt <= '0;
            words_in <= '0;
            ok_out   <= 1'b0;
        end else begin
            state <= state_d;
            if (start) begin
                e3_q     <= eta3;
                cnt_q    <= '0;
                coef_cnt <= '0;
                words_in <= '0;
                ok_out   <= 1'b0;
            end else if (abort) begin
                cnt_q  <= '0;
                ok_out <= 1'b0;
            end else begin
                cnt_q <= cnt_d;
                if (acc)
                    words_in <= words_in + WW'(1);
                if (ld) begin
                    coef_cnt <= coef_cnt + CW'(1);
                    ok_out   <= 1'b1;
                end else if (readout) begin
                    ok_out <= 1'b0;
                end
            end
        end
    end

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        cbd_lane u_lane (
            .clk   (clk),
            .reset (reset),
            .clr   (clr),
            .acc   (acc),
            .ld    (ld),
            .e3    (e3_q),
            .cnt   (cnt_q),
            .din   (din_l[k]),
            .dout  (dout_l[k])
        );
    end
endmodule

// File: tb/tb_cbd_sampler_multi.sv
// Scoreboard bench for cbd_sampler_multi: directed vectors, backpressure, full runs, abort, async reset.
module tb_cbd_sampler_multi;
    localparam int LANES = 2;
    localparam int NCOEF = 256;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic set = 1'b0;
    logic eta3 = 1'b0;
    logic readin = 1'b0;
    logic readout = 1'b0;
    logic [LANES*32-1:0] cbd_din = '0;
    logic ok_in, ok_out, busy, done;
    logic [LANES*16-1:0] cbd_dout;

    int checks = 0;
    int failures = 0;
    int xfers = 0;
    logic [LANES*16-1:0] exp_q[$];
    bit sb [LANES][0:2047];
    int nbits = 0;
    int memit = 0;

    always #5 clk = ~clk;

    cbd_sampler_multi #(.LANES(LANES), .NCOEF(NCOEF)) dut (
        .clk(clk), .reset(reset), .set(set), .eta3(eta3),
        .readin(readin), .cbd_din(cbd_din), .ok_in(ok_in),
        .readout(readout), .cbd_dout(cbd_dout), .ok_out(ok_out),
        .busy(busy), .done(done)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, expv);
        end
    endtask

    function automatic logic [15:0] enc(input int c);
`ifdef CBD_MODQ_EN
        return (c < 0) ? 16'(c + 3329) : 16'(c);
`else
        return 16'(c);
`endif
    endfunction

    // Bitstream model: coefficient j of a lane uses stream bits [j*2E, j*2E+2E)
    task automatic model_push(input logic [LANES*32-1:0] w, input bit e3);
        int s;
        int a;
        int b;
        logic [LANES*16-1:0] v;
        s = e3 ? 6 : 4;
        for (int l = 0; l < LANES; l++)
            for (int i = 0; i < 32; i++)
                sb[l][nbits+i] = w[32*l+i];
        nbits += 32;
        while (memit < NCOEF && nbits >= (memit + 1) * s) begin
            for (int l = 0; l < LANES; l++) begin
                a = 0;
                b = 0;
                for (int k = 0; k < s / 2; k++) begin
                    a += int'(sb[l][memit*s+k]);
                    b += int'(sb[l][memit*s+s/2+k]);
                end
                v[16*l+:16] = enc(a - b);
            end
            exp_q.push_back(v);
            memit++;
        end
    endtask

    always @(negedge clk) begin
        if (reset && ok_out && readout) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL coef_unexpected actual=%0h expected=none", cbd_dout);
            end else begin
                chk("coef", cbd_dout, exp_q.pop_front());
            end
            xfers++;
        end
    end

    // kind 0: random words + model; 1: eta2 directed; 2: eta3 directed
    task automatic run_poly(input bit e3, input int kind, input int stall,
                            input int stop_after, input bit use_rst);
        int nw;
        int acc;
        int cyc;
        bit fin;
        bit hv;
        logic [LANES*16-1:0] held;
        int c0;
        int c1;
        nw = e3 ? 48 : 32;
        acc = 0;
        cyc = 0;
        fin = 0;
        hv = 0;
        held = '0;
        xfers = 0;
        nbits = 0;
        memit = 0;
        exp_q.delete();
        for (int j = 0; j < NCOEF; j++) begin
            if (kind == 1) begin
                c0 = (j == 0) ? 1 : (j == 8) ? -2 : 0;
                c1 = (j == 1) ? 2 : (j == 15) ? -2 : 0;
                exp_q.push_back({enc(c1), enc(c0)});
            end else if (kind == 2) begin
                c0 = (j == 5) ? 2 : 0;
                c1 = (j == 0) ? 3 : 0;
                exp_q.push_back({enc(c1), enc(c0)});
            end
        end
        @(posedge clk);
        #1;
        set = 1'b1;
        eta3 = e3;
        while (!fin && cyc < 5000) begin
            case (kind)
                1: cbd_din = (acc == 0) ? {32'h0000_0030, 32'h0000_0001}
                           : (acc == 1) ? {32'hC000_0000, 32'h0000_000C} : '0;
                2: cbd_din = (acc == 0) ? {32'h0000_0007, 32'hFFFF_FFFF} : '0;
                default: cbd_din = {$urandom, $urandom};
            endcase
            readin = 1'b1;
            readout = (cyc >= stall);
            @(negedge clk);
            if (cyc < stall) begin
                if (hv) begin
                    chk("bp_ok_out_hold", ok_out, 1);
                    chk("bp_dout_hold", cbd_dout, held);
                end else if (ok_out) begin
                    held = cbd_dout;
                    hv = 1;
                end
                if (cyc == stall - 1)
                    chk("bp_ok_in_low", ok_in, 0);
            end
            if (ok_in) begin
                if (kind == 0)
                    model_push(cbd_din, e3);
                acc++;
            end
            if (done)
                fin = 1;
            else if (stop_after > 0 && acc == stop_after)
                break;
            else begin
                @(posedge clk);
                #1;
                cyc++;
            end
        end
        readin = 1'b0;
        if (fin) begin
            set = 1'b0;
            chk("accepted_words", acc, nw);
            chk("queue_empty_at_done", exp_q.size(), 0);
            chk("xfer_count", xfers, NCOEF);
            @(negedge clk);
            chk("done_one_cycle", done, 0);
            chk("busy_after_done", busy, 0);
        end else if (stop_after > 0 && acc == stop_after) begin
            if (use_rst) begin
                chk("busy_before_reset", busy, 1);
                #2;
                reset = 1'b0;
                #1;
                chk("rst_ok_out", ok_out, 0);
                chk("rst_ok_in", ok_in, 0);
                chk("rst_busy", busy, 0);
                chk("rst_done", done, 0);
                chk("rst_dout", cbd_dout, 0);
                set = 1'b0;
                @(negedge clk);
                reset = 1'b1;
            end else begin
                set = 1'b0;
                @(posedge clk);
                #1;
                chk("abort_ok_out", ok_out, 0);
                chk("abort_busy", busy, 0);
                chk("abort_done", done, 0);
            end
            exp_q.delete();
        end else begin
            checks++;
            failures++;
            set = 1'b0;
            $display("FAIL timeout actual=%0d_words expected=done", acc);
        end
    endtask

    initial begin
        reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_ok_in", ok_in, 0);
        chk("reset_ok_out", ok_out, 0);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_dout", cbd_dout, 0);
        reset = 1'b1;
        run_poly(1'b0, 1, 0, 0, 1'b0);   // eta2 directed
        run_poly(1'b1, 2, 0, 0, 1'b0);   // eta3, group across word boundary
        run_poly(1'b0, 0, 10, 0, 1'b0);  // backpressure then full run
        run_poly(1'b0, 0, 0, 0, 1'b0);   // full polynomial eta2
        run_poly(1'b0, 0, 0, 5, 1'b0);   // abort after 5 words
        run_poly(1'b1, 0, 0, 0, 1'b0);   // rerun eta3, 48 words
        run_poly(1'b0, 0, 0, 6, 1'b1);   // async reset mid-run
        run_poly(1'b0, 0, 0, 0, 1'b0);   // clean run after reset
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
